// File: rtl/param_vector_lsu.sv
// param_vector_lsu: MEM-stage load/store unit for scalar and vector accesses
// against a single-port, line-wide data RAM. Unit-stride vectors may be
// byte-unaligned and are split over two consecutive lines.
// Optional feature macro VLSU_STRIDE_EN: strided gather/scatter, one element
// per RAM access. Without the macro strideM is ignored.
module param_vector_lsu #(
  parameter int ELEM_W = 16,
  parameter int LANES  = 16,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 14,
  localparam int LW    = LANES * ELEM_W,
  localparam int LB    = LW / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memtoRegM,
  input  logic              memWriteM,
  input  logic              memSrcM,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       strideM,
  input  logic [ELEM_W-1:0] scalarDataIn,
  input  logic [LW-1:0]     vectorDataIn,
  output logic              busy,
  output logic [ELEM_W-1:0] scalarDataOut,
  output logic [LW-1:0]     vectorDataOut,
  input  logic [LW-1:0]     readData,
  output logic              rden,
  output logic              wren,
  output logic [MEM_AW-1:0] ip_address,
  output logic [LB-1:0]     byteena,
  output logic [LW-1:0]     writeData
);

  localparam int EB   = ELEM_W / 8;
  localparam int OFFW = $clog2(LB);
  localparam logic [LB-1:0]   FULL_BE  = '1;
  localparam logic [LB-1:0]   EB_ONES  = LB'((1 << EB) - 1);
  localparam logic [OFFW-1:0] ELEM_MSK = OFFW'(EB - 1);

`ifdef VLSU_STRIDE_EN
  typedef enum logic [2:0] {IDLE, WR1, WR2, RD1, RD2, RDW, STRD, DONE} stateT;
`else
  typedef enum logic [2:0] {IDLE, WR1, WR2, RD1, RD2, RDW, DONE} stateT;
`endif

  stateT state, nextState;

  // Rotate a line left by o bytes: result byte k = source byte (k - o) mod LB.
  function automatic logic [LW-1:0] rotlBytes(input logic [LW-1:0] d, input logic [OFFW-1:0] o);
    logic [2*LW-1:0] t;
    t = {d, d} << (int'(o) * 8);
    return t[2*LW-1:LW];
  endfunction

  // Rotate a line right by o bytes: result byte k = source byte (k + o) mod LB.
  function automatic logic [LW-1:0] rotrBytes(input logic [LW-1:0] d, input logic [OFFW-1:0] o);
    logic [2*LW-1:0] t;
    t = {d, d} >> (int'(o) * 8);
    return t[LW-1:0];
  endfunction

  // Expand a per-byte mask to a per-bit mask.
  function automatic logic [LW-1:0] byteToBitMask(input logic [LB-1:0] m);
    logic [LW-1:0] r;
    for (int k = 0; k < LB; k++) r[8*k +: 8] = {8{m[k]}};
    return r;
  endfunction

  logic              request, isStore, isStrided;
  logic [OFFW-1:0]   offset, scalarOff;
  logic [MEM_AW-1:0] lineIdx, lineNext;
  logic [LW-1:0]     lowLine, mergedLine, rotData;

  assign request   = memtoRegM | memWriteM;
  assign isStore   = memWriteM;
  assign offset    = address[OFFW-1:0];
  assign scalarOff = offset & ~ELEM_MSK;
  assign lineIdx   = MEM_AW'(address >> OFFW);
  assign lineNext  = lineIdx + MEM_AW'(1);
  assign rotData   = rotlBytes(vectorDataIn, offset);
  // Line L supplies bytes o..LB-1, line L+1 bytes 0..o-1; rotating right by o restores vector order.
  assign mergedLine = rotrBytes((lowLine & byteToBitMask(FULL_BE << offset)) |
                                (readData & ~byteToBitMask(FULL_BE << offset)), offset);

`ifdef VLSU_STRIDE_EN
  localparam int CNTW = $clog2(LANES);
  logic [CNTW-1:0]   elemCnt;
  logic [ADDR_W-1:0] strAddr;
  logic [OFFW-1:0]   strOff, prevOff;
  logic [LW-1:0]     gatherBuf, gatherFinal;

  assign isStrided = memSrcM && (strideM != 16'd0);
  assign strOff    = strAddr[OFFW-1:0] & ~ELEM_MSK;

  // Last lane arrives in RDW and is merged straight into the committed result.
  always_comb begin
    gatherFinal = gatherBuf;
    gatherFinal[(LANES-1)*ELEM_W +: ELEM_W] = readData[int'(prevOff)*8 +: ELEM_W];
  end

  // Element walker for gather/scatter: running address, element count, partial gather.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elemCnt   <= '0;
      strAddr   <= '0;
      prevOff   <= '0;
      gatherBuf <= '0;
    end else begin
      case (state)
        IDLE: begin
          elemCnt <= '0;
          strAddr <= address;
        end
        STRD: begin
          elemCnt <= elemCnt + CNTW'(1);
          strAddr <= strAddr + {{(ADDR_W-16){strideM[15]}}, strideM};
          prevOff <= strOff;
          if (!isStore && elemCnt != '0)
            gatherBuf[(int'(elemCnt)-1)*ELEM_W +: ELEM_W] <= readData[int'(prevOff)*8 +: ELEM_W];
        end
        DONE:    elemCnt <= '0;
        default: ;
      endcase
    end
  end
`else
  logic unusedStride;
  assign isStrided    = 1'b0;
  assign unusedStride = ^{strideM, address};
`endif

  // State register; reset returns to IDLE immediately, even mid-operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state decode and RAM strobes, active only in access states.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    nextState  = state;
    rden       = 1'b0;
    wren       = 1'b0;
    ip_address = '0;
    byteena    = '0;
    writeData  = '0;
    case (state)
      IDLE: if (request) begin
        if (isStrided) begin
`ifdef VLSU_STRIDE_EN
          nextState = STRD;
`endif
        end else begin
          nextState = isStore ? WR1 : RD1;
        end
      end
      WR1: begin
        wren       = 1'b1;
        ip_address = lineIdx;
        if (memSrcM) begin
          writeData = rotData;
          byteena   = FULL_BE << offset;
          nextState = (offset != '0) ? WR2 : DONE;
        end else begin
          writeData = {LANES{scalarDataIn}};
          byteena   = EB_ONES << scalarOff;
          nextState = DONE;
        end
      end
      WR2: begin
        wren       = 1'b1;
        ip_address = lineNext;
        writeData  = rotData;
        byteena    = ~(FULL_BE << offset);
        nextState  = DONE;
      end
      RD1: begin
        rden       = 1'b1;
        ip_address = lineIdx;
        nextState  = (memSrcM && offset != '0) ? RD2 : RDW;
      end
      RD2: begin
        rden       = 1'b1;
        ip_address = lineNext;
        nextState  = RDW;
      end
      RDW: nextState = DONE;
`ifdef VLSU_STRIDE_EN
      STRD: begin
        ip_address = MEM_AW'(strAddr >> OFFW);
        if (isStore) begin
          wren      = 1'b1;
          byteena   = EB_ONES << strOff;
          writeData = {LANES{vectorDataIn[int'(elemCnt)*ELEM_W +: ELEM_W]}};
        end else begin
          rden = 1'b1;
        end
        if (elemCnt == CNTW'(LANES-1)) nextState = isStore ? DONE : RDW;
      end
`endif
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Stall the core while a request is pending or in flight; never during reset.
  always_comb begin
    busy = !reset && ((state == IDLE && request) || (state != IDLE && state != DONE));
  end

  // Load result registers; written only when a load completes in RDW.
  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scalarDataOut <= '0;
      vectorDataOut <= '0;
      lowLine       <= '0;
    end else begin
      if (state == RD2) lowLine <= readData;
      if (state == RDW) begin
        if (!memSrcM) begin
          scalarDataOut <= readData[int'(scalarOff)*8 +: ELEM_W];
`ifdef VLSU_STRIDE_EN
        end else if (isStrided) begin
          vectorDataOut <= gatherFinal;
`endif
        end else if (offset == '0) begin
          vectorDataOut <= readData;
        end else begin
          vectorDataOut <= mergedLine;
        end
      end
    end
  end

endmodule
